// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer: run-time selection modes.
package stream_mux_pkg;

  localparam logic [1:0] MODE_SEL  = 2'd0;
  localparam logic [1:0] MODE_PRIO = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;

  // Mode 3 is reserved and behaves as explicit select, so only 1 and 2
  // route through the shared scanner.
  function automatic logic mode_uses_arb(input logic [1:0] mode);
    return (mode == MODE_PRIO) || (mode == MODE_RR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Circular first-request scanner: returns a one-hot grant for the first
// asserted request found scanning upward from i_start, wrapping at NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 3,
  parameter int SELW   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SELW-1:0]   i_start,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_grant
);

  // Scan NUM_CH positions from i_start; the first hit wins.
  always_comb begin
    logic [SELW:0] idx;
    logic          found;
    o_grant = '0;
    idx     = '0;
    found   = 1'b0;
    if (i_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = {1'b0, i_start} + (SELW+1)'(k);
        if (idx >= (SELW+1)'(NUM_CH)) begin
          idx = idx - (SELW+1)'(NUM_CH);
        end
        if (!found && i_req[idx[SELW-1:0]]) begin
          o_grant[idx[SELW-1:0]] = 1'b1;
          found                  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// Registered N-channel stream multiplexer. Source selection is explicit,
// fixed priority (highest index wins) or round-robin; the output register
// supports backpressure and reloads back-to-back without bubbles.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 3,
  parameter int SELW   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [SELW-1:0]         sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         out_ch
);

  logic [NUM_CH-1:0] w_sel_grant;
  logic [NUM_CH-1:0] w_rev_req;
  logic [NUM_CH-1:0] w_arb_req;
  logic [SELW-1:0]   w_arb_start;
  logic              w_arb_en;
  logic [NUM_CH-1:0] w_arb_grant;
  logic [NUM_CH-1:0] w_prio_grant;
  logic [NUM_CH-1:0] w_grant;
  logic [SELW-1:0]   w_rr_start;
  logic              w_load_en;
  logic              w_xfer;
  logic [SELW-1:0]   w_g_idx;
  logic [WIDTH-1:0]  w_g_data;

  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [SELW-1:0]   r_out_ch;
  logic [SELW-1:0]   r_rr_ptr;

  // Explicit select: an out-of-range sel matches no channel, so no grant.
  always_comb begin
    w_sel_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SELW'(i)) begin
        w_sel_grant[i] = in_valid[i];
      end
    end
  end

  // Bit-reverse requests so an upward scan from 0 finds the highest index.
  always_comb begin
    w_rev_req = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      w_rev_req[j] = in_valid[NUM_CH-1-j];
    end
  end

  // Round-robin scan starts one past the last winner; rr_ptr is checked last.
  assign w_rr_start = (r_rr_ptr == SELW'(NUM_CH-1)) ? '0 : r_rr_ptr + 1'b1;

  // Steer the shared scanner between priority and round-robin use.
  always_comb begin
    w_arb_en    = mode_uses_arb(mode);
    w_arb_req   = (mode == MODE_RR) ? in_valid   : w_rev_req;
    w_arb_start = (mode == MODE_RR) ? w_rr_start : '0;
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SELW   (SELW)
  ) u_rr_arbiter (
    .i_req   (w_arb_req),
    .i_start (w_arb_start),
    .i_en    (w_arb_en),
    .o_grant (w_arb_grant)
  );

  // Undo the request reversal for the priority-mode grant.
  always_comb begin
    w_prio_grant = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      w_prio_grant[j] = w_arb_grant[NUM_CH-1-j];
    end
  end

  // Final grant per mode; mode 3 falls through to explicit select.
  always_comb begin
    w_grant = w_sel_grant;
    case (mode)
      MODE_PRIO: w_grant = w_prio_grant;
      MODE_RR:   w_grant = w_arb_grant;
      default:   w_grant = w_sel_grant;
    endcase
  end

  assign w_load_en = !r_out_valid || out_ready;
  assign in_ready  = (rst_n && w_load_en) ? w_grant : '0;
  assign w_xfer    = |(in_valid & in_ready);

  // Encode the granted channel and pick its data with a one-hot OR mux.
  always_comb begin
    w_g_idx  = '0;
    w_g_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_g_idx  = SELW'(i);
        w_g_data = w_g_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer; both hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SELW'(NUM_CH-1);
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_data  <= w_g_data;
        r_out_ch    <= w_g_idx;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          r_rr_ptr <= w_g_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

endmodule
